// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types and burst helpers for the per-slave arbiter.
package ahb_slave_arbiter_pkg;

  localparam int unsigned HTRANS_W = 2;
  localparam int unsigned HBURST_W = 3;
  localparam int unsigned BEAT_W   = 5;

  typedef enum logic [HTRANS_W-1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [HBURST_W-1:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // Beats in a burst; 0 means undefined length (INCR).
  function automatic logic [BEAT_W-1:0] burst_beats(input hburst_type b);
    case (b)
      BURST_SINGLE:              burst_beats = BEAT_W'(1);
      BURST_WRAP4, BURST_INCR4:   burst_beats = BEAT_W'(4);
      BURST_WRAP8, BURST_INCR8:   burst_beats = BEAT_W'(8);
      BURST_WRAP16, BURST_INCR16: burst_beats = BEAT_W'(16);
      default:                   burst_beats = BEAT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_arbiter_picker.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module ahb_rr_picker #(
  parameter int unsigned MASTER_NUM = 3,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic                  found,
  output logic [IDX_W-1:0]      idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan ptr+1 .. ptr+MASTER_NUM with an explicit wrap at MASTER_NUM-1.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = ptr;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      w_cand = (w_cand == IDX_W'(MASTER_NUM - 1)) ? '0 : w_cand + IDX_W'(1);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave round-robin arbiter holding the grant across bursts and locks.
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 3,
  parameter int unsigned IDX_W      = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [MASTER_NUM-1:0]          hreq,
  input  logic [MASTER_NUM*HTRANS_W-1:0] htrans,
  input  logic [MASTER_NUM*HBURST_W-1:0] hburst,
  input  logic [MASTER_NUM-1:0]          hmastlock,
  input  logic                           hready,
  output logic [MASTER_NUM-1:0]          hgrant,
  output logic                           hsel,
  output logic [IDX_W-1:0]               hmaster_addr,
  output logic [IDX_W-1:0]               hmaster_data,
  output logic                           hmaster_data_valid
);

  arb_state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_owner, w_owner_nxt;
  logic [IDX_W-1:0]       r_rr_ptr, w_rr_nxt;
  logic [BEAT_W-1:0]      r_beat_cnt, w_beat_nxt;
  logic [MASTER_NUM-1:0]  r_hgrant, w_grant_nxt;
  logic [IDX_W-1:0]       r_data_idx;
  logic                   r_data_valid;

  htrans_type             w_trans [MASTER_NUM];
  hburst_type             w_burst [MASTER_NUM];
  htrans_type             w_own_trans;
  hburst_type             w_own_burst;
  logic [BEAT_W-1:0]      w_beats;
  logic                   w_active, w_accept, w_held, w_rearb;
  logic                   w_found;
  logic [IDX_W-1:0]       w_pick_idx;

  // Split the flat per-master buses into typed views.
  for (genvar g = 0; g < MASTER_NUM; g++) begin : g_unpack
    assign w_trans[g] = htrans_type'(htrans[g*HTRANS_W +: HTRANS_W]);
    assign w_burst[g] = hburst_type'(hburst[g*HBURST_W +: HBURST_W]);
  end

  assign w_own_trans = w_trans[r_owner];
  assign w_own_burst = w_burst[r_owner];
  assign w_beats     = burst_beats(w_own_burst);
  assign hsel        = (r_state == ST_OWNED) & hreq[r_owner];
  assign w_active    = (w_own_trans == TRANS_NONSEQ) | (w_own_trans == TRANS_SEQ);
  assign w_accept    = hready & hsel & w_active;

  ahb_rr_picker #(
    .MASTER_NUM (MASTER_NUM),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req   (hreq),
    .ptr   (r_rr_ptr),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  // Next owner, pointer, beat count and grant.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_beat_nxt  = r_beat_cnt;
    w_grant_nxt = r_hgrant;
    w_held      = 1'b0;
    w_rearb     = 1'b0;

    if (hready) begin
      if (!hsel) begin
        w_beat_nxt = '0;
      end else if (w_accept && (w_own_trans == TRANS_NONSEQ)) begin
        w_beat_nxt = (w_beats > BEAT_W'(1)) ? BEAT_W'(w_beats - BEAT_W'(1)) : '0;
      end else if (w_accept && (w_own_trans == TRANS_SEQ) && (r_beat_cnt != '0)) begin
        w_beat_nxt = BEAT_W'(r_beat_cnt - BEAT_W'(1));
      end
    end

    // A dropped request (hsel low) always releases, whatever the burst state.
    w_held  = hsel & (hmastlock[r_owner] | (w_own_trans == TRANS_BUSY) |
                      (w_beat_nxt != '0) | ((w_own_burst == BURST_INCR) & w_active));
    w_rearb = hready & ~w_held;

    if (w_rearb) begin
      if (w_found) begin
        w_state_nxt = ST_OWNED;
        w_owner_nxt = w_pick_idx;
        w_rr_nxt    = w_pick_idx;
        w_grant_nxt = MASTER_NUM'(1) << w_pick_idx;
      end else begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = '0;
        w_grant_nxt = '0;
      end
    end
  end

  // State registers and the data-phase pipeline stage.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= IDX_W'(MASTER_NUM - 1);
      r_beat_cnt   <= '0;
      r_hgrant     <= '0;
      r_data_idx   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_hgrant   <= w_grant_nxt;
      if (hready) begin
        r_data_idx   <= r_owner;
        r_data_valid <= w_accept;
      end
    end
  end

  assign hgrant             = r_hgrant;
  assign hmaster_addr       = r_owner;
  assign hmaster_data       = r_data_idx;
  assign hmaster_data_valid = r_data_valid;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Randomized and directed checks of ahb_slave_arbiter against a behavioural model.
module tb_ahb_slave_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_WRAP4  = 3'd2;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;

  logic          hclk;
  logic          hreset;
  logic [N-1:0]  hreq;
  logic [2*N-1:0] htrans;
  logic [3*N-1:0] hburst;
  logic [N-1:0]  hmastlock;
  logic          hready;
  logic [N-1:0]  hgrant;
  logic          hsel;
  logic [IW-1:0] hmaster_addr;
  logic [IW-1:0] hmaster_data;
  logic          hmaster_data_valid;

  int n_checks;
  int n_errors;

  // Reference model state: owner -1 means nobody owns the slave.
  int m_owner;
  int m_rr;
  int m_beats;
  int m_data;
  bit m_valid;
  int len_tbl [8];

  ahb_slave_arbiter #(.MASTER_NUM(N), .IDX_W(IW)) dut (
    .hclk               (hclk),
    .hreset             (hreset),
    .hreq               (hreq),
    .htrans             (htrans),
    .hburst             (hburst),
    .hmastlock          (hmastlock),
    .hready             (hready),
    .hgrant             (hgrant),
    .hsel               (hsel),
    .hmaster_addr       (hmaster_addr),
    .hmaster_data       (hmaster_data),
    .hmaster_data_valid (hmaster_data_valid)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the arbiter as described by its rules.
  task automatic model_edge();
    int  own, tr, bu, ln, c;
    bit  sel, act, acc, hold, found;
    if (hreset) begin
      m_owner = -1; m_rr = N - 1; m_beats = 0; m_data = 0; m_valid = 1'b0;
      return;
    end
    if (!hready) return;
    own = m_owner;
    sel = (own >= 0) && hreq[own];
    tr  = sel ? int'(htrans[own*2 +: 2]) : 0;
    bu  = sel ? int'(hburst[own*3 +: 3]) : 0;
    act = (tr == 2) || (tr == 3);
    acc = sel && act;
    if (!sel) m_beats = 0;
    else if (acc && tr == 2) begin
      ln = len_tbl[bu];
      m_beats = (ln > 1) ? ln - 1 : 0;
    end else if (acc && tr == 3 && m_beats > 0) m_beats = m_beats - 1;
    hold = sel && (hmastlock[own] || tr == 1 || m_beats != 0 || (bu == 1 && act));
    m_data  = (own < 0) ? 0 : own;
    m_valid = acc;
    if (!hold) begin
      m_owner = -1;
      found   = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_rr + k) % N;
        if (!found && hreq[c]) begin
          found = 1'b1; m_owner = c;
        end
      end
      if (found) m_rr = m_owner;
    end
  endtask

  task automatic step();
    logic [31:0] eg, ea;
    logic        es;
    @(posedge hclk);
    model_edge();
    #1;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    ea = (m_owner < 0) ? 32'd0 : 32'(m_owner);
    es = (m_owner >= 0) && hreq[m_owner];
    chk("hgrant", 32'(hgrant), eg);
    chk("hsel", 32'(hsel), 32'(es));
    chk("hmaster_addr", 32'(hmaster_addr), ea);
    chk("hmaster_data", 32'(hmaster_data), 32'(m_data));
    chk("data_valid", 32'(hmaster_data_valid), 32'(m_valid));
  endtask

  task automatic set_m(input int m, input logic r, input logic [1:0] t,
                       input logic [2:0] b, input logic l);
    hreq[m]         = r;
    htrans[m*2 +: 2] = t;
    hburst[m*3 +: 3] = b;
    hmastlock[m]    = l;
  endtask

  task automatic clear_in();
    hreq = '0; htrans = '0; hburst = '0; hmastlock = '0; hready = 1'b1;
  endtask

  task automatic do_reset();
    clear_in();
    hreset = 1'b1;
    step();
    step();
    hreset = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_rot [4];
    hclk = 1'b0;
    n_checks = 0;
    n_errors = 0;
    len_tbl = '{1, 0, 4, 4, 8, 8, 16, 16};
    m_owner = -1; m_rr = N - 1; m_beats = 0; m_data = 0; m_valid = 1'b0;
    hreset = 1'b1;
    clear_in();

    // Reset state
    do_reset();
    chk("rst_grant", 32'(hgrant), 32'd0);
    chk("rst_valid", 32'(hmaster_data_valid), 32'd0);

    // Single request, grant latency and data phase
    set_m(0, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
    step();
    chk("t1_grant", 32'(hgrant), 32'd1);
    chk("t1_hsel", 32'(hsel), 32'd1);
    step();
    chk("t1_data", 32'(hmaster_data), 32'd0);
    chk("t1_valid", 32'(hmaster_data_valid), 32'd1);

    // All masters SINGLE: rotation
    do_reset();
    for (int m = 0; m < N; m++) set_m(m, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
    exp_rot = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_rotate", 32'(hgrant), 32'(exp_rot[i]));
    end

    // INCR4 with wait states held against a competing requester
    do_reset();
    set_m(1, 1'b1, T_NONSEQ, B_INCR4, 1'b0);
    step();
    chk("t3_own", 32'(hgrant), 32'd2);
    set_m(0, 1'b1, T_IDLE, B_SINGLE, 1'b0);
    step();
    set_m(1, 1'b1, T_SEQ, B_INCR4, 1'b0);
    step();
    hready = 1'b0;
    step();
    step();
    chk("t3_wait", 32'(hgrant), 32'd2);
    hready = 1'b1;
    step();
    chk("t3_beat3", 32'(hgrant), 32'd2);
    step();
    chk("t3_handoff", 32'(hgrant), 32'd1);

    // Locked IDLE transfers hold the grant
    do_reset();
    set_m(2, 1'b1, T_IDLE, B_SINGLE, 1'b1);
    step();
    chk("t4_own", 32'(hgrant), 32'd4);
    set_m(0, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_lock", 32'(hgrant), 32'd4);
    end
    hmastlock[2] = 1'b0;
    step();
    chk("t4_unlock", 32'(hgrant), 32'd1);

    // Request drop aborts an INCR8
    do_reset();
    set_m(0, 1'b1, T_NONSEQ, B_INCR8, 1'b0);
    step();
    set_m(1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
    step();
    set_m(0, 1'b1, T_SEQ, B_INCR8, 1'b0);
    step();
    step();
    chk("t5_held", 32'(hgrant), 32'd1);
    hreq[0] = 1'b0;
    step();
    chk("t5_abort", 32'(hgrant), 32'd2);

    // Reset during a WRAP4
    do_reset();
    set_m(0, 1'b1, T_NONSEQ, B_WRAP4, 1'b0);
    step();
    step();
    set_m(0, 1'b1, T_SEQ, B_WRAP4, 1'b0);
    hreset = 1'b1;
    step();
    chk("t6_grant", 32'(hgrant), 32'd0);
    chk("t6_hsel", 32'(hsel), 32'd0);
    chk("t6_addr", 32'(hmaster_addr), 32'd0);
    chk("t6_valid", 32'(hmaster_data_valid), 32'd0);
    hreset = 1'b0;
    set_m(0, 1'b1, T_IDLE, B_SINGLE, 1'b0);
    set_m(1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
    step();
    chk("t6_first", 32'(hgrant), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < N; m++) begin
        hreq[m]          = ($urandom_range(0, 9) < 7);
        htrans[m*2 +: 2] = 2'($urandom_range(0, 3));
        hburst[m*3 +: 3] = 3'($urandom_range(0, 7));
        hmastlock[m]     = ($urandom_range(0, 9) == 0);
      end
      hready = ($urandom_range(0, 3) != 0);
      hreset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
